fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning PC, instruction and data width.
REQ-002 SHALL have parameter OP_BITS, default 4, meaning width of each instruction field.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port mem_req  output  1  meaning instruction read request.
REQ-007 SHALL have port mem_addr  output  WIDTH  meaning read address, equal to PC.
REQ-008 SHALL have port mem_ack  input  1  meaning mem_rdata valid this cycle.
REQ-009 SHALL have port mem_rdata  input  WIDTH  meaning fetched instruction word.
REQ-010 SHALL have port pc_src  input  2  meaning next-PC select from the controller.
REQ-011 SHALL have port jump_target  input  WIDTH  meaning register-B value for jumps.
REQ-012 SHALL have port exec_done  input  1  meaning current instruction finished.
REQ-013 SHALL have ports op_code, A_index, ext_op_code, B_index  output  OP_BITS each  meaning IR[15:12], IR[11:8], IR[7:4], IR[3:0].
REQ-014 SHALL have port imm  output  8  meaning IR[7:0].
REQ-015 SHALL have port instr_valid  output  1  meaning one-cycle pulse: new instruction on field outputs.
REQ-016 SHALL have port pc_plus_one  output  WIDTH  meaning PC+1 of the issued instruction, for link writes.
REQ-017 SHALL have port fetch_fault  output  1  meaning sticky fetch-timeout flag.

Function
REQ-018 SHALL implement states START, FETCH, ISSUE, EXEC, FAULT; reset state START.
REQ-019 START SHALL last one cycle, then go to FETCH.
REQ-020 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal PC; mem_req is 0 in every other state.
REQ-021 In FETCH, when mem_ack=1 the IR SHALL capture mem_rdata and the state SHALL go to ISSUE; otherwise FETCH is held.
REQ-022 mem_ack outside FETCH SHALL be ignored.
REQ-023 ISSUE SHALL last one cycle with instr_valid=1, then go to EXEC.
REQ-024 Field outputs SHALL reflect IR continuously and change only on IR capture.
REQ-025 In EXEC, exec_done SHALL be sampled; on exec_done=1 PC updates and the state goes to FETCH; exec_done outside EXEC SHALL be ignored.
REQ-026 PC update SHALL be: pc_src 00 or 10 -> PC+1; 01 -> jump_target; 11 -> PC + sign-extended imm.
REQ-027 All PC arithmetic SHALL be modulo 2^WIDTH (16'hFFFF+1 = 16'h0000).
REQ-028 Minimum latency SHALL be: ack in cycle N, instr_valid N+1, exec_done earliest N+2, next mem_req N+3.
REQ-029 pc_plus_one SHALL equal PC+1 (wrapped) throughout ISSUE and EXEC.

Reset
REQ-030 On reset assertion, PC=RESET_PC, IR=0, instr_valid=0, mem_req=0, fetch_fault=0, state START, immediately and regardless of clock.
REQ-031 Reset mid-fetch SHALL abandon the request; a late mem_ack SHALL be ignored.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL count consecutive FETCH cycles without mem_ack; it clears on entry to FETCH and on ack.
REQ-033 With FETCH_TIMEOUT_EN, 16 consecutive FETCH cycles without ack SHALL move the state to FAULT; FAULT sets fetch_fault=1, holds mem_req=0 and is left only by reset.
REQ-034 Without FETCH_TIMEOUT_EN, no counter or FAULT state SHALL exist; fetch_fault is tied to 0 and FETCH waits indefinitely.

Structure
REQ-035 Package cpu_pkg SHALL hold the state encoding, the pc_src encodings (PC_INC=10, PC_JUMP=01, PC_BRANCH=11), IR field bit positions and the timeout limit (16).
REQ-036 The timeout counter SHALL be sub-module fetch_timer, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-037 Reset, RESET_PC=0, mem_ack one cycle after req with 16'h0123 -> mem_addr=0, instr_valid pulse, op_code=0, A_index=1, ext_op_code=2, B_index=3.
REQ-038 exec_done with pc_src=01, jump_target=16'h4000 -> next mem_addr=16'h4000; pc_plus_one was 16'h0001.
REQ-039 PC=16'h0010, imm=8'hFE, pc_src=11 -> next mem_addr=16'h000E.
REQ-040 PC=16'hFFFF, pc_src=10 -> next mem_addr=16'h0000.
REQ-041 FETCH_TIMEOUT_EN, mem_ack never asserted -> fetch_fault=1 after 16 FETCH cycles, mem_req=0 until reset.
REQ-042 Reset asserted while mem_req=1, then mem_ack in START -> ack ignored, IR stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch front end.
//   - fetch_state_e : FSM state encoding (FAULT exists only with FETCH_TIMEOUT_EN)
//   - PC_* : next-PC select encodings driven by the controller
//   - *_LSB / IMM_BITS : instruction-register field positions
//   - FETCH_TIMEOUT / TIMER_BITS : fetch watchdog limit and counter width
// Optional feature macro: FETCH_TIMEOUT_EN
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
`ifdef FETCH_TIMEOUT_EN
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
`else
        ST_EXEC  = 3'd3
`endif
    } fetch_state_e;

    // pc_src encodings; 2'b00 is treated the same as PC_INC.
    localparam logic [1:0] PC_INC_ALT = 2'b00;
    localparam logic [1:0] PC_JUMP    = 2'b01;
    localparam logic [1:0] PC_INC     = 2'b10;
    localparam logic [1:0] PC_BRANCH  = 2'b11;

    // Instruction layout: op[15:12] A[11:8] ext[7:4] B[3:0], imm[7:0].
    localparam int OP_LSB   = 12;
    localparam int A_LSB    = 8;
    localparam int EXT_LSB  = 4;
    localparam int B_LSB    = 0;
    localparam int IMM_LSB  = 0;
    localparam int IMM_BITS = 8;

    localparam int FETCH_TIMEOUT = 16;
    localparam int TIMER_BITS    = 4;

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive FETCH cycles without an acknowledge.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (not in FETCH, or ack seen)
//   tick       : a FETCH cycle without ack
//   expired    : this tick is the FETCH_TIMEOUT-th consecutive one
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timer
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [TIMER_BITS-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + TIMER_BITS'(1);
        end
    end

    // count holds the number of earlier waiting cycles, so the current tick
    // is number count+1.
    assign expired = tick && (count == TIMER_BITS'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch / issue sequencer.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   mem_req, mem_addr     : instruction read request, address = PC
//   mem_ack, mem_rdata    : read data valid / instruction word
//   pc_src, jump_target   : next-PC select and jump destination
//   exec_done             : current instruction finished (sampled in EXEC)
//   op_code, A_index, ext_op_code, B_index, imm : IR fields
//   instr_valid           : one-cycle pulse in ISSUE
//   pc_plus_one           : PC+1 for link writes
//   fetch_fault           : sticky fetch timeout flag (0 unless FETCH_TIMEOUT_EN)
//   state_dbg             : current FSM state (fetch_state_e encoding)
// Handshake: the read is a request/ack pair; mem_req stays high for the whole
// FETCH state, and the word is taken in the first cycle with mem_ack=1.
// mem_ack outside FETCH and exec_done outside EXEC carry no meaning.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch watchdog and FAULT state).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               OP_BITS  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [WIDTH-1:0]   mem_addr,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic [1:0]         pc_src,
    input  logic [WIDTH-1:0]   jump_target,
    input  logic               exec_done,
    output logic [OP_BITS-1:0] op_code,
    output logic [OP_BITS-1:0] A_index,
    output logic [OP_BITS-1:0] ext_op_code,
    output logic [OP_BITS-1:0] B_index,
    output logic [7:0]         imm,
    output logic               instr_valid,
    output logic [WIDTH-1:0]   pc_plus_one,
    output logic               fetch_fault,
    output logic [2:0]         state_dbg
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, ir_q;
    logic [WIDTH-1:0] next_pc, imm_sext;
    logic             ir_load, pc_load;
    logic             timer_expired;

`ifdef FETCH_TIMEOUT_EN
    fetch_timer u_fetch_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_q != ST_FETCH) || mem_ack),
        .tick    ((state_q == ST_FETCH) && !mem_ack),
        .expired (timer_expired)
    );
    assign fetch_fault = (state_q == ST_FAULT);
`else
    assign timer_expired = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_START;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q <= mem_rdata;
            if (pc_load) pc_q <= next_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_ISSUE;
                end else if (timer_expired) begin
`ifdef FETCH_TIMEOUT_EN
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_ISSUE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (exec_done) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_START;
        endcase
    end

    // Branch offset: imm sign-extended to WIDTH; all sums wrap modulo 2^WIDTH.
    assign imm_sext = {{(WIDTH-IMM_BITS){ir_q[IMM_LSB+IMM_BITS-1]}}, ir_q[IMM_LSB +: IMM_BITS]};

    always_comb begin
        next_pc = pc_q + WIDTH'(1);
        case (pc_src)
            PC_JUMP:   next_pc = jump_target;
            PC_BRANCH: next_pc = pc_q + imm_sext;
            default:   next_pc = pc_q + WIDTH'(1);
        endcase
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign pc_plus_one = pc_q + WIDTH'(1);
    assign state_dbg   = state_q;

    assign op_code     = ir_q[OP_LSB  +: OP_BITS];
    assign A_index     = ir_q[A_LSB   +: OP_BITS];
    assign ext_op_code = ir_q[EXT_LSB +: OP_BITS];
    assign B_index     = ir_q[B_LSB   +: OP_BITS];
    assign imm         = ir_q[IMM_LSB +: IMM_BITS];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (default parameters).
// The reference model is a single program counter updated by the next-PC
// rules; instruction fields are taken straight from the word handed to the DUT.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [1:0]  pc_src;
    logic [15:0] jump_target;
    logic        exec_done;
    logic [3:0]  op_code, A_index, ext_op_code, B_index;
    logic [7:0]  imm;
    logic        instr_valid;
    logic [15:0] pc_plus_one;
    logic        fetch_fault;
    logic [2:0]  state_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_pc;

    fetch_unit #(.WIDTH(16), .OP_BITS(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc_src      (pc_src),
        .jump_target (jump_target),
        .exec_done   (exec_done),
        .op_code     (op_code),
        .A_index     (A_index),
        .ext_op_code (ext_op_code),
        .B_index     (B_index),
        .imm         (imm),
        .instr_valid (instr_valid),
        .pc_plus_one (pc_plus_one),
        .fetch_fault (fetch_fault),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference next-PC rule.
    function automatic logic [15:0] ref_next_pc(input logic [15:0] pc, input logic [1:0] src,
                                                input logic [15:0] jt, input logic [15:0] instr);
        int sum;
        case (src)
            2'b01:   return jt;
            2'b11: begin
                sum = int'(pc) + int'($signed(instr[7:0]));
                return 16'(sum & 32'hFFFF);
            end
            default: return 16'((int'(pc) + 1) & 32'hFFFF);
        endcase
    endfunction

    // Wait (bounded) for a fetch request; returns at a falling edge.
    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One complete instruction: fetch, issue, execute, next fetch address.
    task automatic run_instr(input logic [15:0] instr, input logic [1:0] src,
                             input logic [15:0] jt, input int ack_dly, input int exec_dly);
        bit          ok;
        logic [15:0] exp_next;
        wait_fetch(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fetch_wait: mem_req=%b required 1", mem_req);
            return;
        end
        n_checks++;
        if (mem_addr !== model_pc) begin
            n_fail++;
            $display("FAIL mem_addr: got %h required %h", mem_addr, model_pc);
        end
        repeat (ack_dly) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_hold: mem_req=%b required 1 after %0d idle cycles", mem_req, ack_dly);
        end
        mem_rdata = instr;
        mem_ack   = 1'b1;
        @(negedge clk);                         // ISSUE
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        n_checks++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL issue: instr_valid=%b mem_req=%b required 1/0", instr_valid, mem_req);
        end
        n_checks++;
        if ({op_code, A_index, ext_op_code, B_index} !== instr || imm !== instr[7:0]) begin
            n_fail++;
            $display("FAIL fields: got %h%h%h%h imm %h required %h", op_code, A_index,
                     ext_op_code, B_index, imm, instr);
        end
        n_checks++;
        if (pc_plus_one !== 16'(model_pc + 16'd1)) begin
            n_fail++;
            $display("FAIL pc_plus_one_issue: got %h required %h", pc_plus_one, 16'(model_pc + 16'd1));
        end
        // exec_done during ISSUE must not redirect the PC.
        exec_done   = 1'b1;
        pc_src      = 2'b01;
        jump_target = 16'($urandom);
        @(negedge clk);                         // EXEC
        exec_done = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse: instr_valid=%b required 0 in EXEC", instr_valid);
        end
        // Stray acks with fresh data while executing must not touch the IR.
        repeat (exec_dly) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            pc_src    = 2'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_checks++;
        if ({op_code, A_index, ext_op_code, B_index} !== instr || mem_req !== 1'b0 ||
            pc_plus_one !== 16'(model_pc + 16'd1)) begin
            n_fail++;
            $display("FAIL exec_hold: ir=%h%h%h%h mem_req=%b pc1=%h required %h 0 %h",
                     op_code, A_index, ext_op_code, B_index, mem_req, pc_plus_one,
                     instr, 16'(model_pc + 16'd1));
        end
        exp_next    = ref_next_pc(model_pc, src, jt, instr);
        pc_src      = src;
        jump_target = jt;
        exec_done   = 1'b1;
        @(negedge clk);                         // FETCH
        exec_done   = 1'b0;
        jump_target = 16'($urandom);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_next) begin
            n_fail++;
            $display("FAIL next_pc: mem_req=%b mem_addr=%h required 1 %h (src=%b)",
                     mem_req, mem_addr, exp_next, src);
        end
        model_pc = exp_next;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0 ||
            state_dbg !== 3'd0 || mem_addr !== 16'h0000 ||
            {op_code, A_index, ext_op_code, B_index} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b fault=%b state=%0d addr=%h ir=%h%h%h%h required all 0",
                     mem_req, instr_valid, fetch_fault, state_dbg, mem_addr,
                     op_code, A_index, ext_op_code, B_index);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle: mem_req=%b required 0", mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_fetch: mem_req=%b mem_addr=%h required 1 0000", mem_req, mem_addr);
        end
        model_pc = 16'h0000;
    endtask

    task automatic test_directed;
        run_instr(16'h0123, 2'b01, 16'h4000, 0, 0);     // jump, minimum latency
        run_instr(16'hA5C3, 2'b01, 16'h0010, 1, 2);     // move to 0x0010
        run_instr(16'h70FE, 2'b11, 16'h1234, 0, 0);     // branch -2 -> 0x000E
        run_instr(16'h1111, 2'b01, 16'hFFFF, 0, 1);     // move to 0xFFFF
        run_instr(16'h2222, 2'b10, 16'h5555, 2, 0);     // wrap to 0x0000
        run_instr(16'h3380, 2'b11, 16'h0000, 0, 0);     // branch -128 wraps below 0
        run_instr(16'h447F, 2'b00, 16'h0000, 0, 0);     // 00 behaves as increment
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            run_instr(16'($urandom), 2'($urandom), 16'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_fetch;
        bit ok;
        wait_fetch(ok);
        reset = 1'b1;
        #1;
        n_checks++;
        if (!ok || mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0000 ||
            {op_code, A_index, ext_op_code, B_index} !== 16'h0000 || pc_plus_one !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: ok=%b req=%b valid=%b addr=%h ir=%h%h%h%h pc1=%h",
                     ok, mem_req, instr_valid, mem_addr, op_code, A_index, ext_op_code,
                     B_index, pc_plus_one);
        end
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;                       // late ack lands in START
        mem_rdata = 16'hABCD;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || op_code !== 4'h0 || imm !== 8'h00) begin
            n_fail++;
            $display("FAIL late_ack: req=%b addr=%h op=%h imm=%h required 1 0000 0 00",
                     mem_req, mem_addr, op_code, imm);
        end
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack_issue: valid=%b req=%b required 0 1", instr_valid, mem_req);
        end
        model_pc = 16'h0000;
        run_instr(16'h5A5A, 2'b10, 16'h0000, 0, 0);
    endtask

    task automatic test_no_ack;
        bit ok;
        int req_low;
        wait_fetch(ok);
        req_low = ok ? 0 : 1;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1) req_low++;
        end
        n_checks++;
        if (req_low != 0 || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: low_cycles=%0d fault=%b required 0 0", req_low, fetch_fault);
        end
        @(negedge clk);
        n_checks++;
        if (fetch_fault !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: fault=%b req=%b required 1 0", fetch_fault, mem_req);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        exec_done = 1'b1;
        repeat (5) @(negedge clk);
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        n_checks++;
        if (fetch_fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky: fault=%b req=%b valid=%b required 1 0 0",
                     fetch_fault, mem_req, instr_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b required 0", fetch_fault);
        end
        @(negedge clk);
        reset    = 1'b0;
        model_pc = 16'h0000;
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || fetch_fault !== 1'b0) req_low++;
        end
        n_checks++;
        if (req_low != 0 || mem_addr !== model_pc) begin
            n_fail++;
            $display("FAIL fetch_wait_forever: bad_cycles=%0d addr=%h required 0 %h",
                     req_low, mem_addr, model_pc);
        end
`endif
        run_instr(16'h6789, 2'b11, 16'h0000, 0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        pc_src      = 2'b10;
        jump_target = 16'h0000;
        exec_done   = 1'b0;
        model_pc    = 16'h0000;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_fetch();
        test_no_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
